// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv_pkg
//  Purpose  : Shared types for the convolution loop sequencer: FSM state
//             encoding, address-unit verdict codes and the loop tuple.
//  Revision : 1.0
// ============================================================================
package conv_pkg;

    localparam int TUP_H_W = 3;
    localparam int TUP_W_W = 3;
    localparam int TUP_R_W = 3;
    localparam int TUP_S_W = 3;
    localparam int TUP_K_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] COMP_ALL  = 2'd0;
    localparam logic [1:0] COMP_AB   = 2'd1;
    localparam logic [1:0] COMP_BC   = 2'd2;
    localparam logic [1:0] COMP_NONE = 2'd3;

    typedef struct packed {
        logic [TUP_H_W-1:0] h;
        logic [TUP_W_W-1:0] w;
        logic [TUP_R_W-1:0] r;
        logic [TUP_S_W-1:0] s;
        logic [TUP_K_W-1:0] k;
    } tuple_t;

endpackage
`default_nettype wire

// File: rtl/conv_loop_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv_loop_sequencer_if
//  Purpose  : Slot tuples and one-shot start/finish handshake between the
//             loop sequencer (master) and the address unit (slave).
//  Revision : 1.0
// ============================================================================
interface conv_loop_sequencer_if #(
    parameter int H_W = 3,
    parameter int W_W = 3,
    parameter int R_W = 3,
    parameter int S_W = 3,
    parameter int K_W = 3
);
    logic [H_W-1:0] Ah, Bh, Ch;
    logic [W_W-1:0] Aw, Bw, Cw;
    logic [R_W-1:0] Ar, Br, Cr;
    logic [S_W-1:0] As, Bs, Cs;
    logic [K_W-1:0] Ak, Bk, Ck;
    logic [2:0]     slot_vld;
    logic           addr_start;
    logic           addr_finish;
    logic [1:0]     addr_comp;

    modport master (
        output Ah, Aw, Ar, As, Ak,
        output Bh, Bw, Br, Bs, Bk,
        output Ch, Cw, Cr, Cs, Ck,
        output slot_vld, addr_start,
        input  addr_finish, addr_comp
    );

    modport slave (
        input  Ah, Aw, Ar, As, Ak,
        input  Bh, Bw, Br, Bs, Bk,
        input  Ch, Cw, Cr, Cs, Ck,
        input  slot_vld, addr_start,
        output addr_finish, addr_comp
    );
endinterface
`default_nettype wire

// File: rtl/loop_nest_incr.sv
`default_nettype none
// ============================================================================
//  Module   : loop_nest_incr
//  Purpose  : Combinational successor of an (h,w,r,s,k) tuple, k innermost;
//             o_wrap flags the step past the last tuple of the nest.
//  Revision : 1.0
// ============================================================================
module loop_nest_incr
    import conv_pkg::*;
(
    input  tuple_t i_tup,
    input  tuple_t i_bnd,
    output tuple_t o_nxt,
    output logic   o_wrap
);

    logic w_k_last;
    logic w_s_last;
    logic w_r_last;
    logic w_w_last;
    logic w_h_last;

    // Bounds are never zero here, so bound-1 is always the last index.
    assign w_k_last = (i_tup.k == i_bnd.k - TUP_K_W'(1));
    assign w_s_last = (i_tup.s == i_bnd.s - TUP_S_W'(1));
    assign w_r_last = (i_tup.r == i_bnd.r - TUP_R_W'(1));
    assign w_w_last = (i_tup.w == i_bnd.w - TUP_W_W'(1));
    assign w_h_last = (i_tup.h == i_bnd.h - TUP_H_W'(1));

    always_comb begin
        o_nxt   = i_tup;
        o_nxt.k = w_k_last ? '0 : i_tup.k + TUP_K_W'(1);
        if (w_k_last) begin
            o_nxt.s = w_s_last ? '0 : i_tup.s + TUP_S_W'(1);
        end
        if (w_k_last && w_s_last) begin
            o_nxt.r = w_r_last ? '0 : i_tup.r + TUP_R_W'(1);
        end
        if (w_k_last && w_s_last && w_r_last) begin
            o_nxt.w = w_w_last ? '0 : i_tup.w + TUP_W_W'(1);
        end
        if (w_k_last && w_s_last && w_r_last && w_w_last) begin
            o_nxt.h = w_h_last ? '0 : i_tup.h + TUP_H_W'(1);
        end
    end

    assign o_wrap = w_k_last & w_s_last & w_r_last & w_w_last & w_h_last;

endmodule
`default_nettype wire

// File: rtl/conv_loop_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : conv_loop_sequencer
//  Purpose  : Walks the (h,w,r,s,k) loop nest three tuples per group, drives
//             the address unit handshake and counts its equality verdicts.
//  Revision : 1.0
// ============================================================================
module conv_loop_sequencer
    import conv_pkg::*;
#(
    parameter int H_W   = 3,
    parameter int W_W   = 3,
    parameter int R_W   = 3,
    parameter int S_W   = 3,
    parameter int K_W   = 3,
    parameter int CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [H_W-1:0]       i_cfg_h,
    input  logic [W_W-1:0]       i_cfg_w,
    input  logic [R_W-1:0]       i_cfg_r,
    input  logic [S_W-1:0]       i_cfg_s,
    input  logic [K_W-1:0]       i_cfg_k,
    conv_loop_sequencer_if.master addr,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CNT_W-1:0]     o_match_ab,
    output logic [CNT_W-1:0]     o_match_bc,
    output logic [CNT_W-1:0]     o_groups
);

    localparam logic [1:0] c_IDLE  = ST_IDLE;
    localparam logic [1:0] c_ISSUE = ST_ISSUE;
    localparam logic [1:0] c_WAIT  = ST_WAIT;
    localparam logic [1:0] c_DONE  = ST_DONE;

    logic [1:0]       r_state;
    tuple_t           r_bnd;
    tuple_t           r_cur;
    tuple_t           r_a;
    tuple_t           r_b;
    tuple_t           r_c;
    logic [2:0]       r_vld;
    logic             r_more;
    logic [CNT_W-1:0] r_ab;
    logic [CNT_W-1:0] r_bc;
    logic [CNT_W-1:0] r_grp;

    tuple_t w_cfg_bnd;
    tuple_t w_inc_in;
    tuple_t w_inc_bnd;
    tuple_t w_nxt0;
    tuple_t w_nxt1;
    logic   w_wrap0;
    logic   w_wrap1;
    logic   w_accept;
    logic   w_finish;
    logic   w_load;
    logic   w_hit_ab;
    logic   w_hit_bc;

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v,
                                                   input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        w_cfg_bnd   = '0;
        w_cfg_bnd.h = (i_cfg_h == '0) ? TUP_H_W'(1) : i_cfg_h;
        w_cfg_bnd.w = (i_cfg_w == '0) ? TUP_W_W'(1) : i_cfg_w;
        w_cfg_bnd.r = (i_cfg_r == '0) ? TUP_R_W'(1) : i_cfg_r;
        w_cfg_bnd.s = (i_cfg_s == '0) ? TUP_S_W'(1) : i_cfg_s;
        w_cfg_bnd.k = (i_cfg_k == '0) ? TUP_K_W'(1) : i_cfg_k;
    end

    // The first incrementer doubles as the cursor advance: in ISSUE it steps
    // past slot C so the next group's base is ready before finish arrives.
    always_comb begin
        w_inc_in = r_cur;
        if (r_state == c_IDLE) begin
            w_inc_in = '0;
        end else if (r_state == c_ISSUE) begin
            w_inc_in = r_c;
        end
    end

    assign w_inc_bnd = (r_state == c_IDLE) ? w_cfg_bnd : r_bnd;

    loop_nest_incr u_incr_ab (
        .i_tup  (w_inc_in),
        .i_bnd  (w_inc_bnd),
        .o_nxt  (w_nxt0),
        .o_wrap (w_wrap0)
    );

    loop_nest_incr u_incr_bc (
        .i_tup  (w_nxt0),
        .i_bnd  (w_inc_bnd),
        .o_nxt  (w_nxt1),
        .o_wrap (w_wrap1)
    );

    assign w_accept = (r_state == c_IDLE) & i_start & ~i_abort;
    assign w_finish = (r_state == c_WAIT) & addr.addr_finish & ~i_abort;
    assign w_load   = w_accept | (w_finish & r_more);
    assign w_hit_ab = ((addr.addr_comp == COMP_ALL) || (addr.addr_comp == COMP_AB)) && r_vld[1];
    assign w_hit_bc = ((addr.addr_comp == COMP_ALL) || (addr.addr_comp == COMP_BC)) && r_vld[2];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_IDLE;
            r_bnd   <= '0;
            r_cur   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_vld   <= '0;
            r_more  <= 1'b0;
            r_ab    <= '0;
            r_bc    <= '0;
            r_grp   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_state <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_state <= i_abort ? c_IDLE : c_WAIT;
                end
                c_WAIT: begin
                    if (i_abort) begin
                        r_state <= c_IDLE;
                    end else if (addr.addr_finish) begin
                        r_state <= r_more ? c_ISSUE : c_DONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase

            if (w_accept) begin
                r_bnd  <= w_cfg_bnd;
                r_cur  <= '0;
                r_more <= 1'b0;
                r_ab   <= '0;
                r_bc   <= '0;
                r_grp  <= '0;
            end

            // Slots past the end of the nest are zeroed and flagged invalid.
            if (w_load) begin
                r_a   <= w_inc_in;
                r_b   <= w_wrap0 ? '0 : w_nxt0;
                r_c   <= (w_wrap0 | w_wrap1) ? '0 : w_nxt1;
                r_vld <= {~w_wrap0 & ~w_wrap1, ~w_wrap0, 1'b1};
            end

            if (r_state == c_ISSUE) begin
                r_cur  <= w_nxt0;
                r_more <= r_vld[2] & ~w_wrap0;
            end

            if (w_finish) begin
                r_ab  <= f_sat_inc(r_ab, w_hit_ab);
                r_bc  <= f_sat_inc(r_bc, w_hit_bc);
                r_grp <= f_sat_inc(r_grp, 1'b1);
            end
        end
    end

    assign addr.Ah = r_a.h;
    assign addr.Aw = r_a.w;
    assign addr.Ar = r_a.r;
    assign addr.As = r_a.s;
    assign addr.Ak = r_a.k;
    assign addr.Bh = r_b.h;
    assign addr.Bw = r_b.w;
    assign addr.Br = r_b.r;
    assign addr.Bs = r_b.s;
    assign addr.Bk = r_b.k;
    assign addr.Ch = r_c.h;
    assign addr.Cw = r_c.w;
    assign addr.Cr = r_c.r;
    assign addr.Cs = r_c.s;
    assign addr.Ck = r_c.k;

    assign addr.slot_vld   = r_vld;
    assign addr.addr_start = (r_state == c_ISSUE);

    assign o_busy     = (r_state != c_IDLE);
    assign o_done     = (r_state == c_DONE);
    assign o_match_ab = r_ab;
    assign o_match_bc = r_bc;
    assign o_groups   = r_grp;

endmodule
`default_nettype wire

// File: tb/tb_conv_loop_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_loop_sequencer
//  Purpose  : Directed scoreboard bench for conv_loop_sequencer with a
//             behavioural address unit answering each group.
//  Revision : 1.0
// ============================================================================
module tb_conv_loop_sequencer;

    typedef struct {
        bit          is_done;
        int          cyc;
        logic [14:0] a;
        logic [14:0] b;
        logic [14:0] c;
        logic [2:0]  vld;
        int          ab;
        int          bc;
        int          grp;
    } ev_t;

    logic        i_clk   = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [2:0]  cfg_h = '0, cfg_w = '0, cfg_r = '0, cfg_s = '0, cfg_k = '0;
    logic        o_busy, o_done;
    logic [15:0] o_match_ab, o_match_bc, o_groups;
    logic [1:0]  comp_val = 2'd0;

    int  cyc = 0, t0 = 0, vectors = 0, errors = 0;
    int  m_grp = 0, delay_grp = -1, delay_amt = 0, hold_left = 0;
    bit  pending = 1'b0;
    ev_t exp_q[$];
    ev_t m_e;
    ev_t m_last;
    logic [47:0] m_cur;

    conv_loop_sequencer_if addr_if ();

    conv_loop_sequencer dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_cfg_h    (cfg_h),
        .i_cfg_w    (cfg_w),
        .i_cfg_r    (cfg_r),
        .i_cfg_s    (cfg_s),
        .i_cfg_k    (cfg_k),
        .addr       (addr_if),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_match_ab (o_match_ab),
        .o_match_bc (o_match_bc),
        .o_groups   (o_groups)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    assign addr_if.addr_comp = comp_val;

    function automatic logic [14:0] tp(input int h, input int w, input int r,
                                       input int s, input int k);
        return {3'(h), 3'(w), 3'(r), 3'(s), 3'(k)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc - t0);
        end
    endtask

    function automatic void push_grp(input int c, input logic [14:0] a, input logic [14:0] b,
                                     input logic [14:0] cc, input logic [2:0] v);
        ev_t e;
        e.is_done = 1'b0; e.cyc = c; e.a = a; e.b = b; e.c = cc; e.vld = v;
        e.ab = 0; e.bc = 0; e.grp = 0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_done(input int c, input int ab, input int bc, input int g);
        ev_t e;
        e.is_done = 1'b1; e.cyc = c; e.a = '0; e.b = '0; e.c = '0; e.vld = '0;
        e.ab = ab; e.bc = bc; e.grp = g;
        exp_q.push_back(e);
    endfunction

    // Behavioural address unit: finish one cycle after start, optionally late.
    always @(negedge i_clk) begin
        if (i_rst_n && addr_if.addr_start) begin
            pending   = 1'b1;
            hold_left = (m_grp == delay_grp) ? delay_amt : 0;
            m_grp++;
        end
    end

    initial begin
        addr_if.addr_finish = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            addr_if.addr_finish = 1'b0;
            if (pending && i_rst_n) begin
                if (hold_left == 0) begin
                    addr_if.addr_finish = 1'b1;
                    pending = 1'b0;
                end else begin
                    hold_left--;
                end
            end
        end
    end

    // Monitor: pops an expected event whenever the DUT issues or completes.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            m_cur = {addr_if.Ah, addr_if.Aw, addr_if.Ar, addr_if.As, addr_if.Ak,
                     addr_if.Bh, addr_if.Bw, addr_if.Br, addr_if.Bs, addr_if.Bk,
                     addr_if.Ch, addr_if.Cw, addr_if.Cr, addr_if.Cs, addr_if.Ck,
                     addr_if.slot_vld};
            if (addr_if.addr_start || o_done) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_event: start=%0b done=%0b at cycle %0d, required none",
                             addr_if.addr_start, o_done, cyc - t0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("event_kind", o_done, m_e.is_done);
                    chk("event_cycle", cyc - t0, m_e.cyc);
                    if (!m_e.is_done) begin
                        m_last = m_e;
                        chk("slot_vld", addr_if.slot_vld, m_e.vld);
                        chk("slot_A", m_cur[47:33], m_e.a);
                        chk("slot_B", m_cur[32:18], m_e.b);
                        chk("slot_C", m_cur[17:3], m_e.c);
                    end else begin
                        chk("match_ab", o_match_ab, m_e.ab);
                        chk("match_bc", o_match_bc, m_e.bc);
                        chk("groups", o_groups, m_e.grp);
                    end
                end
            end else if (o_busy) begin
                chk("slots_held", m_cur, {m_last.a, m_last.b, m_last.c, m_last.vld});
            end
        end
    end

    task automatic do_start(input int h, input int w, input int r, input int s, input int k);
        cfg_h = 3'(h); cfg_w = 3'(w); cfg_r = 3'(r); cfg_s = 3'(s); cfg_k = 3'(k);
        @(posedge i_clk);
        #1;
        i_start = 1'b1;
        t0      = cyc;
        m_grp   = 0;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_rel(input int r);
        int n = 0;
        while ((cyc - t0 < r) && (n < 100)) begin
            @(posedge i_clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((o_busy || exp_q.size() != 0) && (n < budget)) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        if (n >= budget) begin
            vectors++;
            errors++;
            $display("FAIL run_timeout: busy=%0b pending=%0d after %0d cycles, required idle",
                     o_busy, exp_q.size(), n);
        end
        chk("queue_drained", exp_q.size(), 0);
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_start", addr_if.addr_start, 0);
        chk("rst_vld", addr_if.slot_vld, 0);
        chk("rst_groups", o_groups, 0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        repeat (2) @(posedge i_clk);

        // Zero trip counts behave as one: a single lone tuple.
        comp_val = 2'd0;
        push_grp(1, tp(0,0,0,0,0), 15'd0, 15'd0, 3'b001);
        push_done(3, 0, 0, 1);
        do_start(0, 0, 0, 0, 0);
        wait_idle(50);

        // k=3 fills exactly one group.
        comp_val = 2'd3;
        push_grp(1, tp(0,0,0,0,0), tp(0,0,0,0,1), tp(0,0,0,0,2), 3'b111);
        push_done(3, 0, 0, 1);
        do_start(1, 1, 1, 1, 3);
        wait_idle(50);

        // k=4: second group has only slot A; its verdicts are masked.
        comp_val = 2'd0;
        push_grp(1, tp(0,0,0,0,0), tp(0,0,0,0,1), tp(0,0,0,0,2), 3'b111);
        push_grp(3, tp(0,0,0,0,3), 15'd0, 15'd0, 3'b001);
        push_done(5, 1, 1, 2);
        do_start(1, 1, 1, 1, 4);
        wait_idle(50);

        // s=2,k=2 carries from k into s.
        comp_val = 2'd1;
        push_grp(1, tp(0,0,0,0,0), tp(0,0,0,0,1), tp(0,0,0,1,0), 3'b111);
        push_grp(3, tp(0,0,0,1,1), 15'd0, 15'd0, 3'b001);
        push_done(5, 1, 0, 2);
        do_start(1, 1, 1, 2, 2);
        wait_idle(50);

        // w=r=s=2: carries through three levels; last group leaves C empty.
        comp_val = 2'd0;
        push_grp(1, tp(0,0,0,0,0), tp(0,0,0,1,0), tp(0,0,1,0,0), 3'b111);
        push_grp(3, tp(0,0,1,1,0), tp(0,1,0,0,0), tp(0,1,0,1,0), 3'b111);
        push_grp(5, tp(0,1,1,0,0), tp(0,1,1,1,0), 15'd0, 3'b011);
        push_done(7, 3, 2, 3);
        do_start(1, 2, 2, 2, 1);
        wait_idle(60);

        // Finish withheld 3 cycles in group 0, stray start mid-run.
        comp_val  = 2'd2;
        delay_grp = 0;
        delay_amt = 3;
        push_grp(1, tp(0,0,0,0,0), tp(0,0,0,0,1), tp(1,0,0,0,0), 3'b111);
        push_grp(6, tp(1,0,0,0,1), 15'd0, 15'd0, 3'b001);
        push_done(8, 0, 1, 2);
        do_start(2, 1, 1, 1, 2);
        wait_rel(3);
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        wait_idle(60);
        delay_grp = -1;

        // Abort in WAIT of group 1: counters keep group-0 totals.
        comp_val  = 2'd0;
        delay_grp = 1;
        delay_amt = 2;
        push_grp(1, tp(0,0,0,0,0), tp(0,0,0,0,1), tp(0,0,0,0,2), 3'b111);
        push_grp(3, tp(0,0,0,0,3), tp(0,0,0,0,4), tp(0,0,0,0,5), 3'b111);
        do_start(1, 1, 1, 1, 7);
        wait_rel(4);
        i_abort = 1'b1;
        @(posedge i_clk);
        #1;
        i_abort = 1'b0;
        @(negedge i_clk);
        chk("abort_busy", o_busy, 0);
        chk("abort_done", o_done, 0);
        repeat (4) @(posedge i_clk);
        #1;
        chk("abort_ab", o_match_ab, 1);
        chk("abort_bc", o_match_bc, 1);
        chk("abort_groups", o_groups, 1);
        chk("abort_queue", exp_q.size(), 0);
        delay_grp = -1;

        // Asynchronous reset mid-run forces everything to zero at once.
        comp_val = 2'd0;
        push_grp(1, tp(0,0,0,0,0), tp(0,0,0,0,1), tp(0,0,0,0,2), 3'b111);
        push_grp(3, tp(0,0,0,0,3), tp(0,0,0,0,4), tp(0,0,0,0,5), 3'b111);
        do_start(1, 1, 1, 1, 7);
        wait_rel(4);
        #1;
        i_rst_n = 1'b0;
        addr_if.addr_finish = 1'b0;
        pending = 1'b0;
        #1;
        chk("areset_busy", o_busy, 0);
        chk("areset_done", o_done, 0);
        chk("areset_start", addr_if.addr_start, 0);
        chk("areset_vld", addr_if.slot_vld, 0);
        chk("areset_A", {addr_if.Ah, addr_if.Aw, addr_if.Ar, addr_if.As, addr_if.Ak}, 0);
        chk("areset_B", {addr_if.Bh, addr_if.Bw, addr_if.Br, addr_if.Bs, addr_if.Bk}, 0);
        chk("areset_ab", o_match_ab, 0);
        chk("areset_bc", o_match_bc, 0);
        chk("areset_groups", o_groups, 0);
        chk("areset_queue", exp_q.size(), 0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        repeat (2) @(posedge i_clk);

        // Recovery run over h=2.
        comp_val = 2'd1;
        push_grp(1, tp(0,0,0,0,0), tp(1,0,0,0,0), 15'd0, 3'b011);
        push_done(3, 1, 0, 1);
        do_start(2, 1, 1, 1, 1);
        wait_idle(50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_loop_sequencer.md
# conv_loop_sequencer

Sequencer for the convolution address unit. On a start pulse it walks the five-deep loop nest (h, w, r, s, k) over runtime-configured bounds. It packs three consecutive iterations into the unit's A/B/C slots and fires the unit's one-shot start/finish handshake once per group. It also accumulates the unit's address-equality verdicts into counters consumed by the buffer-reuse logic.

## Interface
Parameters:
- H_W, 3, width of h index and bound
- W_W, 3, width of w index and bound
- R_W, 3, width of r index and bound
- S_W, 3, width of s index and bound
- K_W, 3, width of k index and bound
- CNT_W, 16, width of statistics counters

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  start pulse; sampled only in IDLE
- i_abort  in  1  synchronous abort; returns to IDLE next cycle, no o_done
- i_cfg_h / i_cfg_w / i_cfg_r / i_cfg_s / i_cfg_k  in  H_W..K_W  loop trip counts; latched on accepted start
- o_Ah, o_Aw, o_Ar, o_As, o_Ak  out  per-field width  slot A tuple
- o_Bh … o_Bk  out  per-field width  slot B tuple
- o_Ch … o_Ck  out  per-field width  slot C tuple
- o_slot_vld  out  3  {C,B,A} slot valid
- o_addr_start  out  1  one-cycle start to address unit
- i_addr_finish  in  1  finish from address unit
- i_addr_comp  in  2  verdict: 0 A=B=C, 1 A=B only, 2 B=C only, 3 none
- o_busy  out  1  high from ISSUE through DONE inclusive
- o_done  out  1  one-cycle completion pulse
- o_match_ab  out  CNT_W  count of valid A=B verdicts
- o_match_bc  out  CNT_W  count of valid B=C verdicts
- o_groups  out  CNT_W  groups issued

## Operation
- Trip count 0 is treated as 1. Each index runs 0..bound-1. Order is k innermost, then s, r, w, h outermost. N = H·W·R·S·K, maximum 16807.
- States:
  - IDLE: on i_start, latch bounds, clear the cursor and all counters, and go to ISSUE.
  - ISSUE: o_addr_start=1; go to WAIT.
  - WAIT: hold tuples. On i_addr_finish, update counters, then go to ISSUE if tuples remain, else DONE. Without finish, stay in WAIT.
  - DONE: o_done=1; go to IDLE.
- Slot filling:
  - A = cursor, B = next(A), C = next(B).
  - A slot whose index passes the end of the nest has o_slot_vld bit 0 and tuple 0.
  - After a group, cursor = next(C).
- Counting, on finish only:
  - o_match_ab += 1 if comp∈{0,1} and B valid.
  - o_match_bc += 1 if comp∈{0,2} and C valid.
  - o_groups += 1 every group.
  - All counters saturate at 2^CNT_W−1.
- i_start outside IDLE is ignored. i_abort has priority over all transitions and leaves counters frozen. Counters clear only on the next accepted start.
- Tuples and o_slot_vld are registered and remain stable from ISSUE through the WAIT cycle that sees finish.

## Timing
- Reset values:
  - State IDLE.
  - All tuples, o_slot_vld, o_addr_start, o_busy and o_done 0.
  - All counters 0.
- Start sampled at cycle 0. Group g (0-based) issues at cycle 2g+1 and expects finish at cycle 2g+2, because the address unit asserts finish in its single processing cycle.
- G = ceil(N/3) groups. o_done is high at cycle 2G+1 and o_busy falls at cycle 2G+2. A late finish stretches WAIT one cycle per missing-finish cycle.
- Abort asserted in WAIT suppresses that group's counter update. The address unit completes on its own, and its finish is ignored in IDLE.
- Asynchronous reset mid-group forces IDLE immediately with all outputs at their reset values.

## Structure
- Shared package conv_pkg holds:
  - The state enum (IDLE, ISSUE, WAIT, DONE).
  - The comp code constants (COMP_ALL, COMP_AB, COMP_BC, COMP_NONE).
  - The tuple struct {h,w,r,s,k} with the field widths.
- One sub-module, loop_nest_incr: a combinational next-tuple function with inputs (tuple, bounds) and outputs (next tuple, wrap). It is instantiated twice in the slot chain and reused for the cursor advance.

## Test plan
- All bounds 1, start: N=1, G=1. o_slot_vld=001, one o_addr_start at cycle 1, o_done at cycle 3, o_groups=1, match counters 0.
- Bounds h=w=r=s=1, k=3, comp=3: slots carry k=0/1/2, o_slot_vld=111, o_done at cycle 3.
- k=4, all other bounds 1, comp=0 both groups: group 1 o_slot_vld=001. Final o_match_ab=1 and o_match_bc=1, since group-1 verdicts are masked.
- Bounds s=2, k=2, others 1, comp=1: group 0 tuples A=(s0,k0), B=(s0,k1), C=(s1,k0). Group 1 is A=(s1,k1) only. o_done at cycle 5.
- Finish withheld for 3 cycles in group 0: WAIT is held, tuples stay stable, o_done is delayed by 3. i_start pulsed mid-run has no effect.
- Abort in WAIT of group 1, then async reset during a later run: abort gives IDLE next cycle, no o_done, counters frozen; reset forces all outputs to 0 immediately.
